sfx_scheduler: RTL and testbench

Sound-effect scheduler that shares the single tone generator between four game-event requesters: win jingle, lose jingle, platform bump and menu click. It arbitrates by fixed priority, preempts lower-priority sounds and queues one pending request per requester. It also steps each sound through a short note sequence held in a small ROM. It sits between the game FSM / collision logic and the speaker PWM driver, which consumes `tone` as a frequency in Hz.

---
 rtl/sfx_pkg.sv | 48 ++++
 rtl/sfx_rom.sv | 39 +++
 rtl/sfx_scheduler.sv | 156 +++++++++++++++
 tb/tb_sfx_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect scheduler.
//   - FSM state encodings (IDLE, PLAY, GAP)
//   - sound ids, which double as requester bit positions and priorities
//   - SILENCE frequency and the note-index -> Hz map
//   - top_id(): index of the highest set bit of a 4-bit request vector
package sfx_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam logic [1:0] SND_CLICK = 2'd0;
   localparam logic [1:0] SND_BUMP  = 2'd1;
   localparam logic [1:0] SND_LOSE  = 2'd2;
   localparam logic [1:0] SND_WIN   = 2'd3;

   localparam logic [31:0] SILENCE = 32'd20000;

   function automatic logic [31:0] note_hz(input logic [3:0] note);
      logic [31:0] hz;
      case (note)
         4'd1:    hz = 32'd466;
         4'd2:    hz = 32'd523;
         4'd3:    hz = 32'd587;
         4'd4:    hz = 32'd622;
         4'd5:    hz = 32'd659;
         4'd6:    hz = 32'd698;
         4'd7:    hz = 32'd740;
         4'd8:    hz = 32'd784;
         4'd9:    hz = 32'd830;
         4'd10:   hz = 32'd880;
         4'd11:   hz = 32'd1046;
         default: hz = SILENCE;
      endcase
      return hz;
   endfunction

   // Higher bit index means higher priority.
   function automatic logic [1:0] top_id(input logic [3:0] v);
      logic [1:0] id;
      if (v[3])      id = SND_WIN;
      else if (v[2]) id = SND_LOSE;
      else if (v[1]) id = SND_BUMP;
      else           id = SND_CLICK;
      return id;
   endfunction

endpackage

// File: rtl/sfx_rom.sv
// Note-sequence ROM, purely combinational.
//   sound : sound id (0 click .. 3 win)
//   step  : step index within the sound
//   note  : note index for that step
//   dur   : step lasts dur+1 cycles
//   last  : final step of the sound
// Unused addresses read as a silent, zero-length, last step so a stray
// step index always terminates the sound.
module sfx_rom
   import sfx_pkg::*;
(
   input  logic [1:0] sound,
   input  logic [2:0] step,
   output logic [3:0] note,
   output logic [3:0] dur,
   output logic       last
);

   always_comb begin
      note = 4'd0;
      dur  = 4'd0;
      last = 1'b1;
      case ({sound, step})
         {SND_WIN,  3'd0}: begin note = 4'd2;  dur = 4'd1; last = 1'b0; end
         {SND_WIN,  3'd1}: begin note = 4'd3;  dur = 4'd1; last = 1'b0; end
         {SND_WIN,  3'd2}: begin note = 4'd5;  dur = 4'd1; last = 1'b0; end
         {SND_WIN,  3'd3}: begin note = 4'd8;  dur = 4'd2; last = 1'b1; end
         {SND_LOSE, 3'd0}: begin note = 4'd10; dur = 4'd1; last = 1'b0; end
         {SND_LOSE, 3'd1}: begin note = 4'd9;  dur = 4'd1; last = 1'b0; end
         {SND_LOSE, 3'd2}: begin note = 4'd8;  dur = 4'd1; last = 1'b0; end
         {SND_LOSE, 3'd3}: begin note = 4'd7;  dur = 4'd3; last = 1'b1; end
         {SND_BUMP, 3'd0}: begin note = 4'd2;  dur = 4'd0; last = 1'b0; end
         {SND_BUMP, 3'd1}: begin note = 4'd4;  dur = 4'd1; last = 1'b1; end
         {SND_CLICK,3'd0}: begin note = 4'd11; dur = 4'd1; last = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: shares one tone generator between four
// requesters (bit 3 win > bit 2 lose > bit 1 bump > bit 0 click).
//   clk_22    : tick clock, sole clock
//   rst_n     : asynchronous active-low reset
//   enable    : low flushes state and pending requests
//   mute      : forces tone to SILENCE, sequencing continues
//   req       : per-requester request pulses
//   tone      : frequency in Hz to the PWM driver (20000 = silence)
//   grant     : one-hot id of the sound in PLAY, else 0
//   busy      : high in PLAY or GAP
//   done      : one-cycle pulse on the first GAP cycle of a completed sound
//   state_dbg : current FSM state
// All outputs are registered from the next-state values.
module sfx_scheduler
   import sfx_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int GAP_TICKS = 1
) (
   input  logic             clk_22,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             mute,
   input  logic [N_REQ-1:0] req,
   output logic [31:0]      tone,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_dbg
);

   logic [1:0]       state_q,   state_d;
   logic [1:0]       cur_q,     cur_d;
   logic [2:0]       step_q,    step_d;
   logic [3:0]       timer_q,   timer_d;
   logic [3:0]       gap_q,     gap_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [31:0]      tone_q,    tone_d;
   logic [N_REQ-1:0] grant_q,   grant_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;

   logic [N_REQ-1:0] all_req;
   logic [3:0]       cur_note, cur_dur, nxt_note, nxt_dur;
   logic             cur_last, nxt_last;

   // Current step drives the timer; the step being entered drives the note.
   sfx_rom u_rom_cur (.sound(cur_q), .step(step_q), .note(cur_note), .dur(cur_dur), .last(cur_last));
   sfx_rom u_rom_nxt (.sound(cur_d), .step(step_d), .note(nxt_note), .dur(nxt_dur), .last(nxt_last));

   assign all_req = pending_q | req;

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      step_d    = step_q;
      timer_d   = timer_q;
      gap_d     = gap_q;
      pending_d = all_req;
      done_d    = 1'b0;

      if (!enable) begin
         state_d   = ST_IDLE;
         pending_d = '0;
         step_d    = 3'd0;
         timer_d   = 4'd0;
         gap_d     = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|all_req) begin
                  state_d   = ST_PLAY;
                  cur_d     = top_id(all_req);
                  step_d    = 3'd0;
                  timer_d   = 4'd0;
                  pending_d = all_req & ~(N_REQ'(1) << top_id(all_req));
               end
            end
            ST_PLAY: begin
               // A request at or above the current sound preempts or retriggers.
               if ((|req) && (top_id(req) >= cur_q)) begin
                  cur_d     = top_id(req);
                  step_d    = 3'd0;
                  timer_d   = 4'd0;
                  pending_d = all_req & ~(N_REQ'(1) << top_id(req));
               end else if (timer_q == cur_dur) begin
                  timer_d = 4'd0;
                  if (cur_last || (step_q == 3'd7)) begin
                     state_d = ST_GAP;
                     step_d  = 3'd0;
                     gap_d   = 4'd0;
                     done_d  = 1'b1;
                  end else begin
                     step_d = step_q + 3'd1;
                  end
               end else begin
                  timer_d = timer_q + 4'd1;
               end
            end
            ST_GAP: begin
               if (gap_q == 4'(GAP_TICKS - 1)) begin
                  if (|all_req) begin
                     state_d   = ST_PLAY;
                     cur_d     = top_id(all_req);
                     step_d    = 3'd0;
                     timer_d   = 4'd0;
                     pending_d = all_req & ~(N_REQ'(1) << top_id(all_req));
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      tone_d  = ((state_d == ST_PLAY) && !mute) ? note_hz(nxt_note) : SILENCE;
      grant_d = (state_d == ST_PLAY) ? (N_REQ'(1) << cur_d) : '0;
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_22 or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cur_q     <= SND_CLICK;
         step_q    <= 3'd0;
         timer_q   <= 4'd0;
         gap_q     <= 4'd0;
         pending_q <= '0;
         tone_q    <= SILENCE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         step_q    <= step_d;
         timer_q   <= timer_d;
         gap_q     <= gap_d;
         pending_q <= pending_d;
         tone_q    <= tone_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign tone      = tone_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler. Reference model works on whole sounds expanded
// into per-cycle tone lists; expected outputs go into exp_q at each
// sampling edge and are popped and compared on the falling edge.
module tb_sfx_scheduler;

   localparam int GAP_TICKS = 1;
   localparam int SIL       = 20000;

   logic        clk_22 = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        mute;
   logic [3:0]  req;
   logic [31:0] tone;
   logic [3:0]  grant;
   logic        busy;
   logic        done;
   logic [1:0]  state_dbg;

   sfx_scheduler #(.N_REQ(4), .GAP_TICKS(GAP_TICKS)) dut (
      .clk_22(clk_22), .rst_n(rst_n), .enable(enable), .mute(mute), .req(req),
      .tone(tone), .grant(grant), .busy(busy), .done(done), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk_22 = ~clk_22;

   // ---------------- counters / check ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // expected word: {tone[31:0], grant[3:0], busy, done}
   logic [37:0] exp_q[$];

   int seq_t [4][10];
   int seq_len [4];

   int         m_mode;   // 0 idle, 1 play, 2 gap
   int         m_cur;
   int         m_pos;
   int         m_gap;
   logic [3:0] m_pend;

   function automatic int hi_bit(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cur = 0; m_pos = 0; m_gap = 0; m_pend = 4'b0;
   endtask

   task automatic model_start(input int id);
      m_mode = 1; m_cur = id; m_pos = 0;
      m_pend = m_pend & ~(4'b1 << id);
   endtask

   // One clock edge of the model using the inputs sampled at that edge.
   task automatic model_step();
      logic        m_done;
      logic [31:0] e_tone;
      logic [3:0]  e_grant;
      m_done = 1'b0;
      if (!enable) begin
         m_mode = 0; m_pend = 4'b0;
      end else begin
         case (m_mode)
            0: begin
               m_pend = m_pend | req;
               if (m_pend != 0) model_start(hi_bit(m_pend));
            end
            1: begin
               if (req != 0 && hi_bit(req) >= m_cur) begin
                  m_pend = m_pend | req;
                  model_start(hi_bit(req));
               end else begin
                  m_pend = m_pend | req;
                  m_pos++;
                  if (m_pos == seq_len[m_cur]) begin
                     m_mode = 2; m_gap = GAP_TICKS; m_done = 1'b1;
                  end
               end
            end
            default: begin
               m_pend = m_pend | req;
               m_gap--;
               if (m_gap == 0) begin
                  if (m_pend != 0) model_start(hi_bit(m_pend));
                  else m_mode = 0;
               end
            end
         endcase
      end
      e_tone  = (m_mode == 1 && !mute) ? 32'(seq_t[m_cur][m_pos]) : 32'(SIL);
      e_grant = (m_mode == 1) ? (4'b1 << m_cur) : 4'b0;
      exp_q.push_back({e_tone, e_grant, (m_mode != 0), m_done});
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_22) begin
      logic [37:0] e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("tone",  tone,         e[37:6]);
         chk("grant", 32'(grant),   32'(e[5:2]));
         chk("busy",  32'(busy),    32'(e[1]));
         chk("done",  32'(done),    32'(e[0]));
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input logic en, input logic m, input logic [3:0] r);
      enable = en; mute = m; req = r;
      @(posedge clk_22);
      model_step();
      #1;
   endtask

   task automatic idle(input int n, input logic m);
      for (int i = 0; i < n; i++) drive(1'b1, m, 4'b0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tone",  tone,          32'(SIL));
      chk("rst_grant", 32'(grant),    32'd0);
      chk("rst_busy",  32'(busy),     32'd0);
      chk("rst_done",  32'(done),     32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      exp_q.delete();
      model_reset();
      req = 4'b0;
      @(posedge clk_22);
      #2 rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      seq_t[3] = '{523, 523, 587, 587, 659, 659, 784, 784, 784, 0};
      seq_t[2] = '{880, 880, 830, 830, 784, 784, 740, 740, 740, 740};
      seq_t[1] = '{523, 622, 622, 0, 0, 0, 0, 0, 0, 0};
      seq_t[0] = '{1046, 1046, 0, 0, 0, 0, 0, 0, 0, 0};
      seq_len  = '{2, 3, 10, 9};
      model_reset();

      rst_n = 1'b0; enable = 1'b1; mute = 1'b0; req = 4'b0;
      #8;
      chk("init_tone",  tone,       32'(SIL));
      chk("init_grant", 32'(grant), 32'd0);
      chk("init_busy",  32'(busy),  32'd0);
      chk("init_done",  32'(done),  32'd0);
      #4 rst_n = 1'b1;

      // win from idle
      drive(1'b1, 1'b0, 4'b1000);
      idle(13, 1'b0);
      // bump preempted by win during bump's first step
      drive(1'b1, 1'b0, 4'b0010);
      drive(1'b1, 1'b0, 4'b1000);
      idle(14, 1'b0);
      // lose playing, bump and click queued together
      drive(1'b1, 1'b0, 4'b0100);
      idle(3, 1'b0);
      drive(1'b1, 1'b0, 4'b0011);
      idle(20, 1'b0);
      // bump retriggered at step 1
      drive(1'b1, 1'b0, 4'b0010);
      idle(1, 1'b0);
      drive(1'b1, 1'b0, 4'b0010);
      idle(8, 1'b0);
      // muted win
      drive(1'b1, 1'b1, 4'b1000);
      idle(12, 1'b1);
      // flush with pending bits set
      drive(1'b1, 1'b0, 4'b0100);
      drive(1'b1, 1'b0, 4'b0011);
      idle(2, 1'b0);
      drive(1'b0, 1'b0, 4'b0000);
      idle(8, 1'b0);
      // async reset mid-sound, then a fresh request
      drive(1'b1, 1'b0, 4'b1000);
      idle(3, 1'b0);
      async_reset();
      drive(1'b1, 1'b0, 4'b0001);
      idle(5, 1'b0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] r;
         logic       en, m;
         for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 13) == 0);
         en = ($urandom_range(0, 79) != 0);
         m  = ($urandom_range(0, 9) == 0);
         drive(en, m, r);
         if ($urandom_range(0, 999) == 0) async_reset();
      end
      idle(20, 1'b0);

      @(negedge clk_22);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
